// File: rtl/mypio_multi_if.sv
// Avalon-MM slave bus plus level interrupt for the multi-channel PIO.
// Address width follows the channel count: {channel, reg[1:0]}.
interface mypio_multi_if #(
   parameter int unsigned CHANNELS = 2
);
   localparam int unsigned AW = $clog2(CHANNELS) + 2;

   logic [AW-1:0] avs_address;
   logic          avs_read;
   logic          avs_write;
   logic [31:0]   avs_writedata;
   logic [31:0]   avs_readdata;
   logic          irq;

   modport slave (
      input  avs_address, avs_read, avs_write, avs_writedata,
      output avs_readdata, irq
   );

   modport master (
      output avs_address, avs_read, avs_write, avs_writedata,
      input  avs_readdata, irq
   );
endinterface

// File: rtl/mypio_multi.sv
// Multi-channel GPIO: per channel an output register, synchronised input,
// per-bit edge capture (W1C) and irq mask, behind an Avalon-MM slave.
module mypio_multi #(
   parameter int unsigned     WIDTH       = 8,
   parameter int unsigned     CHANNELS    = 2,
   parameter int unsigned     EDGE_MODE   = 0,
   parameter int unsigned     SYNC_STAGES = 2,
   parameter logic [WIDTH-1:0] OUT_RESET  = '0
) (
   input  logic                      clk,
   input  logic                      reset,
   mypio_multi_if.slave              avs,
   input  logic [CHANNELS*WIDTH-1:0] coe_in,
   output logic [CHANNELS*WIDTH-1:0] coe_out
);

   localparam int unsigned NB        = CHANNELS * WIDTH;
   localparam int unsigned PRIME_MAX = SYNC_STAGES + 1;
   localparam int unsigned PW        = $clog2(SYNC_STAGES + 2);

   logic [NB-1:0] sync_q [SYNC_STAGES];
   logic [NB-1:0] sync_d [SYNC_STAGES];
   logic [NB-1:0] prev_q, prev_d;
   logic [NB-1:0] out_q, out_d;
   logic [NB-1:0] edge_q, edge_d;
   logic [NB-1:0] mask_q, mask_d;
   logic [PW-1:0] prime_q, prime_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          irq_q, irq_d;

   logic [NB-1:0] sync_in, rise, fall, det, clr;
   logic [31:0]   ch_sel, rd_val;
   logic [1:0]    reg_sel;
   logic          prime_done;
   logic          wdata_unused;

   assign wdata_unused = ^avs.avs_writedata;

   // Input synchroniser, edge detect and prime counter
   always_comb begin
      sync_d[0] = coe_in;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_d[i] = sync_q[i-1];
      sync_in = sync_q[SYNC_STAGES-1];
      prev_d  = sync_in;
      rise    = sync_in & ~prev_q;
      fall    = ~sync_in & prev_q;
      if (EDGE_MODE == 0)      det = rise;
      else if (EDGE_MODE == 1) det = fall;
      else                     det = rise | fall;
      // Edges are ignored until the zeroed chain has flushed after reset
      prime_done = (prime_q == PW'(PRIME_MAX));
      prime_d    = prime_done ? prime_q : prime_q + PW'(1);
   end

   // Register decode: reads, writes and W1C; an out-of-range channel matches nothing
   always_comb begin
      reg_sel = avs.avs_address[1:0];
      ch_sel  = 32'(avs.avs_address >> 2);
      out_d   = out_q;
      mask_d  = mask_q;
      clr     = '0;
      rd_val  = '0;
      for (int c = 0; c < int'(CHANNELS); c++) begin
         if (ch_sel == 32'(c)) begin
            case (reg_sel)
               2'd0:    rd_val = 32'(out_q[c*WIDTH +: WIDTH]);
               2'd1:    rd_val = 32'(sync_in[c*WIDTH +: WIDTH]);
               2'd2:    rd_val = 32'(edge_q[c*WIDTH +: WIDTH]);
               default: rd_val = 32'(mask_q[c*WIDTH +: WIDTH]);
            endcase
            if (avs.avs_write) begin
               case (reg_sel)
                  2'd0:    out_d[c*WIDTH +: WIDTH]  = avs.avs_writedata[WIDTH-1:0];
                  2'd2:    clr[c*WIDTH +: WIDTH]    = avs.avs_writedata[WIDTH-1:0];
                  2'd3:    mask_d[c*WIDTH +: WIDTH] = avs.avs_writedata[WIDTH-1:0];
                  default: ;
               endcase
            end
         end
      end
      // A new edge wins over a same-cycle clear
      edge_d  = (edge_q & ~clr) | (prime_done ? det : '0);
      irq_d   = |(edge_q & mask_q);
      rdata_d = avs.avs_read ? rd_val : rdata_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
         prev_q  <= '0;
         out_q   <= {CHANNELS{OUT_RESET}};
         edge_q  <= '0;
         mask_q  <= '0;
         prime_q <= '0;
         rdata_q <= '0;
         irq_q   <= 1'b0;
      end else begin
         for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_d[i];
         prev_q  <= prev_d;
         out_q   <= out_d;
         edge_q  <= edge_d;
         mask_q  <= mask_d;
         prime_q <= prime_d;
         rdata_q <= rdata_d;
         irq_q   <= irq_d;
      end
   end

   assign coe_out          = out_q;
   assign avs.avs_readdata = rdata_q;
   assign avs.irq          = irq_q;

endmodule
